// File: rtl/mux_sel_seq_pkg.sv
// rtl/mux_sel_seq_pkg.sv - shared types and defaults for the mux select sequencer
package mux_sel_seq_pkg;

    localparam int DWELL_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CH0  = 2'd1,
        CH1  = 2'd2
    } state_e;

endpackage

// File: rtl/mux_sel_sequencer_dwell_counter.sv
// rtl/mux_sel_sequencer_dwell_counter.sv - dwell down-counter with 0->1 dwell mapping
module dwell_counter
    import mux_sel_seq_pkg::*;
#(
    parameter int W = DWELL_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;

    // A zero dwell behaves as a one-cycle dwell, so it loads the same terminal count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= (load_val == '0) ? '0 : load_val - ONE;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - time-division select sequencer with one-deep sample holding register
// Optional drop-and-flag overrun behaviour: MUX_SEL_SEQ_OVERRUN_EN
module mux_sel_sequencer
    import mux_sel_seq_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell0,
    input  logic [DWELL_W-1:0] dwell1,
    output logic               sel,
    input  logic               y_in,
    output logic               sample_valid,
    output logic               sample_data,
    output logic               sample_ch,
    input  logic               sample_ready,
    input  logic               ovr_clr,
    output logic               overrun
);

`ifdef MUX_SEL_SEQ_OVERRUN_EN
    localparam bit DROP_ON_FULL = 1'b1;
`else
    localparam bit DROP_ON_FULL = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic               valid_q, data_q, ch_q;
    logic               cnt_clr, cnt_load, cnt_dec, cnt_last;
    logic [DWELL_W-1:0] cnt_val;
    logic               cap, hold_full, store;

    dwell_counter #(.W(DWELL_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    assign cap       = (state_q != IDLE) && en && cnt_last;
    assign hold_full = valid_q && !sample_ready;
    assign store     = cap && !(hold_full && DROP_ON_FULL);

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = dwell0;
        case (state_q)
            IDLE: if (en) begin
                state_d  = CH0;
                cnt_load = 1'b1;
            end
            CH0, CH1: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_last) begin
                    state_d  = (state_q == CH0) ? CH1 : CH0;
                    cnt_load = 1'b1;
                    cnt_val  = (state_q == CH0) ? dwell1 : dwell0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
        sel_d = (state_d == CH1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            ch_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (store) begin
                data_q  <= y_in;
                ch_q    <= (state_q == CH1);
                valid_q <= 1'b1;
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef MUX_SEL_SEQ_OVERRUN_EN
    logic overrun_q;

    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (cap && hold_full) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign overrun        = 1'b0;
`endif

    assign sel          = sel_q;
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign sample_ch    = ch_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - directed self-checking bench for mux_sel_sequencer
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst, en, y_in, sample_ready, ovr_clr;
    logic [7:0] dwell0, dwell1;
    logic       sel, sample_valid, sample_data, sample_ch, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    mux_sel_sequencer #(.DWELL_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .dwell0       (dwell0),
        .dwell1       (dwell1),
        .sel          (sel),
        .y_in         (y_in),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_ready (sample_ready),
        .ovr_clr      (ovr_clr),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // The mux is modelled so that y equals the selected channel index.
    assign y_in = sel;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_sel, exp_v, exp_d;
        int   m;

        rst = 1'b1; en = 1'b1; dwell0 = 8'd3; dwell1 = 8'd2;
        sample_ready = 1'b1; ovr_clr = 1'b0;

        tick();
        tick();
        check("rst_sel", sel, 1'b0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_data", sample_data, 1'b0);
        check("rst_ch", sample_ch, 1'b0);
        check("rst_ovr", overrun, 1'b0);

        // Edge 0 enters CH0; edges 1..13 follow the 3/2 pattern with period 5.
        rst = 1'b0;
        tick();
        check("entry_sel", sel, 1'b0);
        check("entry_valid", sample_valid, 1'b0);
        for (int n = 1; n <= 13; n++) begin
            tick();
            m       = n % 5;
            exp_sel = (m == 3) || (m == 4);
            exp_v   = (m == 3) || (m == 0);
            check("run32_sel", sel, exp_sel);
            check("run32_valid", sample_valid, exp_v);
            if (exp_v) begin
                check("run32_data", sample_data, (m == 0));
                check("run32_ch", sample_ch, (m == 0));
            end
        end

        // Now in CH1 with one dwell cycle left: stop and hold the sample.
        en = 1'b0; sample_ready = 1'b0;
        tick();
        check("stop_sel", sel, 1'b0);
        check("stop_valid", sample_valid, 1'b1);
        check("stop_data", sample_data, 1'b0);
        check("stop_ch", sample_ch, 1'b0);
        tick();
        check("idle_sel", sel, 1'b0);
        check("idle_valid", sample_valid, 1'b1);

        en = 1'b1; sample_ready = 1'b1;
        tick();
        check("restart_sel0", sel, 1'b0);
        check("restart_drain", sample_valid, 1'b0);
        tick();
        check("restart_sel1", sel, 1'b0);
        tick();
        check("restart_sel2", sel, 1'b0);
        check("restart_novalid", sample_valid, 1'b0);
        tick();
        check("restart_sel3", sel, 1'b1);
        check("restart_valid", sample_valid, 1'b1);
        check("restart_ch", sample_ch, 1'b0);

        // Zero dwells take effect from the next channel entry.
        dwell0 = 8'd0; dwell1 = 8'd0;
        tick();
        check("z_pre_sel", sel, 1'b1);
        check("z_pre_valid", sample_valid, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_sel = logic'(k % 2);
            check("z_sel", sel, exp_sel);
            check("z_valid", sample_valid, 1'b1);
            check("z_data", sample_data, !exp_sel);
            check("z_ch", sample_ch, !exp_sel);
            check("z_ovr", overrun, 1'b0);
        end

        // Downstream stalls for two full periods; clear pulsed during a drop.
        sample_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ovr_clr = (j == 2);
            tick();
            check("stall_sel", sel, logic'(j % 2));
            check("stall_valid", sample_valid, 1'b1);
`ifdef MUX_SEL_SEQ_OVERRUN_EN
            exp_d = 1'b0;
            check("stall_ovr", overrun, 1'b1);
`else
            exp_d = (j % 2) == 0;
            check("stall_ovr", overrun, 1'b0);
`endif
            check("stall_data", sample_data, exp_d);
            check("stall_ch", sample_ch, exp_d);
        end

        en = 1'b0; ovr_clr = 1'b1;
        tick();
        check("clr_ovr", overrun, 1'b0);
        check("clr_valid", sample_valid, 1'b1);
        check("clr_data", sample_data, 1'b0);
        check("clr_ch", sample_ch, 1'b0);
        check("clr_sel", sel, 1'b0);
        ovr_clr = 1'b0;

        // Reset in the middle of a dwell discards the pending sample.
        en = 1'b1; dwell0 = 8'd3; dwell1 = 8'd2;
        tick();
        tick();
        check("mid_sel", sel, 1'b0);
        check("mid_valid", sample_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", sample_valid, 1'b0);
        check("mid_rst_sel", sel, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_sel", sel, 1'b0);
        check("post_rst_valid", sample_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
